// File: rtl/ncnet_adder_arbiter.sv
// Round-robin arbiter sharing one 2-stage add-add-subtract pipeline among
// several requesters; results return with a one-hot acknowledge.
module ncnet_adder_arbiter #(
  parameter int unsigned P_DATA_WIDTH = 4,
  parameter int unsigned P_NUM_REQ    = 4,
  parameter int unsigned P_ID_WIDTH   = 2
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_en,
  input  logic [P_NUM_REQ-1:0]              i_req,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_add1,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_add2,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_miuns,
  output logic [P_NUM_REQ-1:0]              o_ack,
  output logic [P_ID_WIDTH-1:0]             o_ack_id,
  output logic [P_DATA_WIDTH-1:0]           o_sum,
  output logic                              o_busy
);

  localparam int unsigned W  = P_DATA_WIDTH;
  localparam int unsigned N  = P_NUM_REQ;
  localparam int unsigned IW = P_ID_WIDTH;

  logic [N-1:0]  pend;
  logic [N-1:0]  elig;
  logic [N-1:0]  gnt_oh;
  logic [N-1:0]  ack_next;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_next;
  logic [IW-1:0] gnt_id;
  logic          gnt_vld;
  logic [IW:0]   scan;

  logic [W-1:0]  add1_a  [N];
  logic [W-1:0]  add2_a  [N];
  logic [W-1:0]  miuns_a [N];

  logic          s1_vld;
  logic [W-1:0]  s1_ab;
  logic [W-1:0]  s1_nc;
  logic [IW-1:0] s1_id;

  // Unpack per-requester operand slices
  always_comb begin
    for (int k = 0; k < N; k++) begin
      add1_a[k]  = i_add1[k*W +: W];
      add2_a[k]  = i_add2[k*W +: W];
      miuns_a[k] = i_miuns[k*W +: W];
    end
  end

  // Round-robin pick: first eligible requester at or after ptr, wrapping.
  // Pending requesters stay masked through their ack cycle, so a release
  // edge can never re-grant the same requester.
  always_comb begin
    elig    = i_req & ~pend & {N{i_en}};
    gnt_vld = 1'b0;
    gnt_id  = '0;
    scan    = '0;
    for (int i = 0; i < N; i++) begin
      scan = {1'b0, ptr} + (IW+1)'(i);
      if (scan >= (IW+1)'(N)) begin
        scan = scan - (IW+1)'(N);
      end
      if (!gnt_vld && elig[scan[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = scan[IW-1:0];
      end
    end
    gnt_oh = '0;
    if (gnt_vld) begin
      gnt_oh[gnt_id] = 1'b1;
    end
    ptr_next = ptr;
    if (gnt_vld) begin
      ptr_next = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);
    end
  end

  always_comb begin
    ack_next = '0;
    if (s1_vld) begin
      ack_next[s1_id] = 1'b1;
    end
  end

  // Stage 1 captures the partial sum and negated subtrahend; stage 2 finishes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend     <= '0;
      ptr      <= '0;
      s1_vld   <= 1'b0;
      s1_ab    <= '0;
      s1_nc    <= '0;
      s1_id    <= '0;
      o_ack    <= '0;
      o_ack_id <= '0;
      o_sum    <= '0;
    end else begin
      pend   <= (pend & ~o_ack) | gnt_oh;
      ptr    <= ptr_next;
      s1_vld <= gnt_vld;
      if (gnt_vld) begin
        s1_ab <= add1_a[gnt_id] + add2_a[gnt_id];
        s1_nc <= ~miuns_a[gnt_id] + W'(1);
        s1_id <= gnt_id;
      end
      o_ack <= ack_next;
      if (s1_vld) begin
        o_sum    <= s1_ab + s1_nc;
        o_ack_id <= s1_id;
      end
    end
  end

  assign o_busy = (|pend) | s1_vld;

endmodule

// File: tb/tb_ncnet_adder_arbiter.sv
// Directed bench for ncnet_adder_arbiter: single-op vector table, a per-cycle
// table for four-way contention, and hand sequences for the timing corners.
module tb_ncnet_adder_arbiter;

  localparam int unsigned W  = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N-1:0]    req;
  logic [N*W-1:0]  add1;
  logic [N*W-1:0]  add2;
  logic [N*W-1:0]  miuns;
  logic [N-1:0]    ack;
  logic [IW-1:0]   ack_id;
  logic [W-1:0]    sum;
  logic            busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int k;
    int a;
    int b;
    int m;
    int sum;
  } vec_t;

  typedef struct {
    logic [N-1:0] ack;
    int           id;
    int           sum;
    logic         busy;
  } cyc_t;

  vec_t vecs [7];
  cyc_t seq4 [8];

  ncnet_adder_arbiter #(
    .P_DATA_WIDTH(W),
    .P_NUM_REQ   (N),
    .P_ID_WIDTH  (IW)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (en),
    .i_req   (req),
    .i_add1  (add1),
    .i_add2  (add2),
    .i_miuns (miuns),
    .o_ack   (ack),
    .o_ack_id(ack_id),
    .o_sum   (sum),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int k, input int a, input int b, input int m);
    add1[k*W +: W]  = W'(a);
    add2[k*W +: W]  = W'(b);
    miuns[k*W +: W] = W'(m);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{0, 5, 3, 2, 6};
    vecs[1] = '{2, 15, 15, 0, 14};
    vecs[2] = '{2, 0, 0, 1, 15};
    vecs[3] = '{2, 7, 1, 8, 0};
    vecs[4] = '{1, 9, 9, 3, 15};
    vecs[5] = '{3, 12, 5, 1, 0};
    vecs[6] = '{3, 6, 3, 2, 7};

    seq4[0] = '{4'b0000, 0, 0, 1'b0};
    seq4[1] = '{4'b0000, 0, 0, 1'b1};
    seq4[2] = '{4'b0001, 0, 3, 1'b1};
    seq4[3] = '{4'b0010, 1, 8, 1'b1};
    seq4[4] = '{4'b0100, 2, 0, 1'b1};
    seq4[5] = '{4'b1000, 3, 13, 1'b1};
    seq4[6] = '{4'b0001, 0, 6, 1'b1};
    seq4[7] = '{4'b0000, 0, 0, 1'b0};

    rst = 1'b1; en = 1'b1; req = '0; add1 = '0; add2 = '0; miuns = '0;
    do_reset();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_id", 32'(ack_id), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_busy", 32'(busy), 0);

    // Single operations: latency 2, busy drops one cycle after ack
    for (int v = 0; v < 7; v++) begin
      set_op(vecs[v].k, vecs[v].a, vecs[v].b, vecs[v].m);
      req = '0;
      req[vecs[v].k] = 1'b1;
      tick();
      chk("single_ack_early", 32'(ack), 0);
      chk("single_busy", 32'(busy), 1);
      tick();
      chk("single_ack", 32'(ack), 32'(1) << vecs[v].k);
      chk("single_id", 32'(ack_id), 32'(vecs[v].k));
      chk("single_sum", 32'(sum), 32'(vecs[v].sum));
      chk("single_busy_ack", 32'(busy), 1);
      req = '0;
      tick();
      chk("single_ack_after", 32'(ack), 0);
      chk("single_busy_after", 32'(busy), 0);
    end

    // Four requesters from reset; requester 0 re-requests after its ack
    do_reset();
    set_op(0, 1, 2, 0);
    set_op(1, 4, 5, 1);
    set_op(2, 9, 9, 2);
    set_op(3, 15, 1, 3);
    for (int c = 0; c < 8; c++) begin
      if (c == 3) set_op(0, 6, 6, 6);
      req[0] = (c < 7);
      for (int k = 1; k < 4; k++) req[k] = (c < k + 3);
      chk("rr_ack", 32'(ack), 32'(seq4[c].ack));
      chk("rr_busy", 32'(busy), 32'(seq4[c].busy));
      if (seq4[c].ack != '0) begin
        chk("rr_id", 32'(ack_id), 32'(seq4[c].id));
        chk("rr_sum", 32'(sum), 32'(seq4[c].sum));
      end
      tick();
    end
    req = '0;

    // Requester 1 back-to-back: one ack every 3 cycles
    for (int c = 0; c < 10; c++) begin
      if (c == 0) set_op(1, 3, 4, 1);
      if (c == 3) set_op(1, 10, 10, 5);
      if (c == 6) set_op(1, 0, 0, 0);
      req = (c < 9) ? 4'b0010 : 4'b0000;
      if (c % 3 == 2) begin
        chk("b2b_ack", 32'(ack), 32'h2);
        chk("b2b_sum", 32'(sum), (c == 2) ? 32'd6 : (c == 5) ? 32'd15 : 32'd0);
      end else begin
        chk("b2b_noack", 32'(ack), 0);
      end
      if (c == 9) chk("b2b_busy", 32'(busy), 0);
      tick();
    end

    // Enable gating: in-flight op completes, new grant waits for enable
    en = 1'b1; req = 4'b0001; set_op(0, 2, 2, 1);
    tick();
    en = 1'b0; req = 4'b1001; set_op(3, 5, 5, 5);
    chk("en_e1_ack", 32'(ack), 0);
    tick();
    chk("en_inflight_ack", 32'(ack), 32'h1);
    chk("en_inflight_sum", 32'(sum), 3);
    tick();
    req = 4'b1000;
    for (int c = 3; c < 7; c++) begin
      if (c == 5) en = 1'b1;
      chk("en_gated_ack", 32'(ack), 0);
      tick();
    end
    chk("en_late_ack", 32'(ack), 32'h8);
    chk("en_late_id", 32'(ack_id), 3);
    chk("en_late_sum", 32'(sum), 5);
    req = '0;
    tick();
    chk("en_busy", 32'(busy), 0);

    // Reset mid-op: discard requester 2, pointer returns to 0
    req = 4'b0100; set_op(2, 3, 3, 3);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    req = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("mid_rst_ack_hold", 32'(ack), 0);
      chk("mid_rst_sum", 32'(sum), 0);
      chk("mid_rst_id", 32'(ack_id), 0);
      chk("mid_rst_busy_hold", 32'(busy), 0);
    end
    rst = 1'b0;
    tick();
    chk("post_rst_ack", 32'(ack), 0);
    req = 4'b1010; set_op(1, 1, 1, 1); set_op(3, 8, 4, 2);
    tick();
    chk("post_q1_ack", 32'(ack), 0);
    tick();
    chk("post_first_ack", 32'(ack), 32'h2);
    chk("post_first_id", 32'(ack_id), 1);
    chk("post_first_sum", 32'(sum), 1);
    tick();
    req = 4'b1000;
    chk("post_second_ack", 32'(ack), 32'h8);
    chk("post_second_id", 32'(ack_id), 3);
    chk("post_second_sum", 32'(sum), 10);
    tick();
    req = '0;
    chk("post_end_ack", 32'(ack), 0);
    tick();
    chk("post_end_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
